// File: rtl/ram_probe_pkg.sv
// State encoding shared by the RAM latency probe and its bench-visible STATE output.
package ram_probe_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_NEXT = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_WAIT = ST_WAIT,
    S_NEXT = ST_NEXT,
    S_DONE = ST_DONE
  } state_e;

endpackage

// File: rtl/ram_lat_stats.sv
// Latency statistics accumulator: sum, timeout count and optional min/max.
// Define RAM_LATENCY_MINMAX_EN to build the min/max tracking registers.
module ram_lat_stats #(
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    clear_i,
  input  logic                    valid_i,
  input  logic                    timeout_i,
  input  logic [CNT_W-1:0]        lat_i,
  output logic [CNT_W-1:0]        min_o,
  output logic [CNT_W-1:0]        max_o,
  output logic [CNT_W+ADDR_W-1:0] sum_o,
  output logic [ADDR_W:0]         timeouts_o
);

  logic [CNT_W+ADDR_W-1:0] sum_q, sum_d;
  logic [ADDR_W:0]         to_q, to_d;

  always_comb begin
    sum_d = sum_q;
    to_d  = to_q;
    if (clear_i) begin
      sum_d = '0;
      to_d  = '0;
    end else if (valid_i) begin
      if (timeout_i) to_d = to_q + (ADDR_W+1)'(1);
      else           sum_d = sum_q + (CNT_W+ADDR_W)'(lat_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sum_q <= '0;
      to_q  <= '0;
    end else begin
      sum_q <= sum_d;
      to_q  <= to_d;
    end
  end

  assign sum_o      = sum_q;
  assign timeouts_o = to_q;

`ifdef RAM_LATENCY_MINMAX_EN
  logic [CNT_W-1:0] min_q, min_d, max_q, max_d;

  // Timed-out samples never touch min/max; min starts at all-ones so any real sample wins.
  always_comb begin
    min_d = min_q;
    max_d = max_q;
    if (clear_i) begin
      min_d = '1;
      max_d = '0;
    end else if (valid_i && !timeout_i) begin
      if (lat_i < min_q) min_d = lat_i;
      if (lat_i > max_q) max_d = lat_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      min_q <= '1;
      max_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  assign min_o = min_q;
  assign max_o = max_q;
`else
  assign min_o = '0;
  assign max_o = '0;
`endif

endmodule

// File: rtl/ram_latency_probe.sv
// Sweeps RAM read addresses and measures cycles until RDATA equals the address.
// Define RAM_LATENCY_MINMAX_EN to enable MIN_LAT/MAX_LAT tracking.
module ram_latency_probe
  import ram_probe_pkg::*;
#(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 8,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 2**CNT_W-1
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    START,
  input  logic                    ABORT,
  input  logic [ADDR_W-1:0]       NUM,
  output logic [ADDR_W-1:0]       RADDR,
  input  logic [DATA_W-1:0]       RDATA,
  output logic                    BUSY,
  output logic                    DONE,
  output logic [CNT_W-1:0]        LAST_LAT,
  output logic [CNT_W-1:0]        MIN_LAT,
  output logic [CNT_W-1:0]        MAX_LAT,
  output logic [CNT_W+ADDR_W-1:0] LAT_SUM,
  output logic [ADDR_W:0]         TIMEOUTS,
  output logic [2:0]              STATE
);

  // state | meaning
  // IDLE  | waiting for START, statistics held
  // WAIT  | address issued, counting cycles until data matches or timeout
  // NEXT  | sample recorded, advance address or finish
  // DONE  | one-cycle completion pulse

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
  localparam int EXP_W = (DATA_W < ADDR_W) ? DATA_W : ADDR_W;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d, idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, last_q, last_d;
  logic [DATA_W-1:0] exp_data;
  logic              match, cnt_tc, last_idx, sweep_start, samp_valid;

  always_comb begin
    exp_data = '0;
    for (int i = 0; i < EXP_W; i++) exp_data[i] = raddr_q[i];
  end

  assign match       = (RDATA == exp_data);
  assign cnt_tc      = (cnt_q == TMO);
  assign last_idx    = (idx_q == NUM);
  assign sweep_start = (state_q == S_IDLE) && START;
  assign samp_valid  = (state_q == S_WAIT) && !ABORT && (match || cnt_tc);

  always_ff @(posedge CLK) begin
    if (!RST_N) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (START) state_d = S_WAIT;
      S_WAIT: begin
        if (ABORT)                state_d = S_IDLE;
        else if (match || cnt_tc) state_d = S_NEXT;
      end
      S_NEXT: begin
        if (ABORT)         state_d = S_IDLE;
        else if (last_idx) state_d = S_DONE;
        else               state_d = S_WAIT;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    BUSY  = (state_q == S_WAIT) || (state_q == S_NEXT);
    DONE  = (state_q == S_DONE);
    STATE = state_q;
  end

  // Match has priority over timeout, so a hit on the terminal count still reports TIMEOUT as latency.
  always_comb begin
    raddr_d = raddr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    if (sweep_start) begin
      raddr_d = raddr_q + ADDR_W'(1);
      idx_d   = '0;
      cnt_d   = '0;
      last_d  = '0;
    end else if (state_q == S_WAIT && !ABORT) begin
      if (match)       last_d = cnt_q;
      else if (cnt_tc) last_d = TMO;
      else             cnt_d  = cnt_q + CNT_W'(1);
    end else if (state_q == S_NEXT && !ABORT && !last_idx) begin
      raddr_d = raddr_q + ADDR_W'(1);
      idx_d   = idx_q + ADDR_W'(1);
      cnt_d   = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      raddr_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      last_q  <= '0;
    end else begin
      raddr_q <= raddr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  assign RADDR    = raddr_q;
  assign LAST_LAT = last_q;

  ram_lat_stats #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_stats (
    .clk_i      (CLK),
    .rst_n_i    (RST_N),
    .clear_i    (sweep_start),
    .valid_i    (samp_valid),
    .timeout_i  (!match),
    .lat_i      (cnt_q),
    .min_o      (MIN_LAT),
    .max_o      (MAX_LAT),
    .sum_o      (LAT_SUM),
    .timeouts_o (TIMEOUTS)
  );

endmodule

// File: tb/tb_ram_latency_probe.sv
// Bench for ram_latency_probe: pipelined RAM model whose data equals its address, plus a sweep-level reference model.
module tb_ram_latency_probe;

  localparam int TMO = 5;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        START = 1'b0;
  logic        ABORT = 1'b0;
  logic [3:0]  NUM = '0;
  logic [3:0]  RADDR;
  logic [7:0]  RDATA;
  logic        BUSY, DONE;
  logic [7:0]  LAST_LAT, MIN_LAT, MAX_LAT;
  logic [11:0] LAT_SUM;
  logic [4:0]  TIMEOUTS;
  logic [2:0]  STATE;

  ram_latency_probe #(
    .ADDR_W(4), .DATA_W(8), .CNT_W(8), .TIMEOUT(TMO)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .ABORT(ABORT), .NUM(NUM),
    .RADDR(RADDR), .RDATA(RDATA), .BUSY(BUSY), .DONE(DONE),
    .LAST_LAT(LAST_LAT), .MIN_LAT(MIN_LAT), .MAX_LAT(MAX_LAT),
    .LAT_SUM(LAT_SUM), .TIMEOUTS(TIMEOUTS), .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  // RAM model: data == address, delivered cfg_lat cycles after the address changes; blank returns 0xFF.
  int         cfg_lat = 2;
  bit         cfg_blank = 1'b0;
  logic [3:0] hist [8] = '{default: 4'h0};

  always @(posedge CLK) begin
    hist[0] <= RADDR;
    for (int k = 1; k < 8; k++) hist[k] <= hist[k-1];
  end

  assign RDATA = cfg_blank ? 8'hFF :
                 (cfg_lat == 0) ? {4'h0, RADDR} : {4'h0, hist[cfg_lat-1]};

  int total = 0;
  int bad   = 0;

  logic [7:0]  exp_last, exp_min, exp_max;
  logic [11:0] exp_sum;
  logic [4:0]  exp_to;
  logic [3:0]  exp_addr;
  logic [3:0]  exp_addrs [$];

  logic [3:0]  obs_addrs [$];
  int          obs_done;
  bit          obs_expired, obs_busy_first, obs_done_after;

  // Sweep-level reference: every sample sees the same RAM latency.
  task automatic model_sweep(input logic [3:0] start_a, input int n, input int lat, input bit blank);
    logic [3:0] a;
    exp_sum = '0; exp_to = '0; exp_last = '0; exp_min = 8'hFF; exp_max = '0;
    exp_addrs.delete();
    a = start_a;
    for (int s = 0; s <= n; s++) begin
      a = a + 4'd1;
      exp_addrs.push_back(a);
      if (blank || lat > TMO) begin
        exp_last = 8'(TMO);
        exp_to   = exp_to + 5'd1;
      end else begin
        exp_last = 8'(lat);
        exp_sum  = exp_sum + 12'(lat);
        if (8'(lat) < exp_min) exp_min = 8'(lat);
        if (8'(lat) > exp_max) exp_max = 8'(lat);
      end
    end
    exp_addr = a;
`ifndef RAM_LATENCY_MINMAX_EN
    exp_min = '0;
    exp_max = '0;
`endif
  endtask

  task automatic run_sweep(input int n, input int lat, input bit blank, input bit rand_start);
    logic [3:0] prev;
    int budget;
    cfg_lat = lat; cfg_blank = blank;
    repeat (10) @(negedge CLK);
    obs_addrs.delete(); obs_done = 0; obs_expired = 1'b1;
    NUM = 4'(n); START = 1'b1; prev = RADDR;
    budget = (n + 1) * (TMO + 3) + 20;
    @(negedge CLK);
    obs_busy_first = BUSY;
    for (int c = 0; c < budget; c++) begin
      if (RADDR != prev) begin obs_addrs.push_back(RADDR); prev = RADDR; end
      if (DONE) begin obs_done++; obs_expired = 1'b0; START = 1'b0; break; end
      START = rand_start ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge CLK);
    end
    START = 1'b0;
    @(negedge CLK);
    obs_done_after = DONE;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    total++; if (STATE !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", STATE); end
    total++; if (RADDR !== 4'd0) begin bad++; $display("FAIL reset_raddr got=%0d want=0", RADDR); end
    total++; if (BUSY !== 1'b0 || DONE !== 1'b0) begin bad++; $display("FAIL reset_busy_done got=%b%b want=00", BUSY, DONE); end
    total++; if (LAT_SUM !== 12'd0 || TIMEOUTS !== 5'd0 || LAST_LAT !== 8'd0) begin
      bad++; $display("FAIL reset_stats sum=%0d to=%0d last=%0d want=0", LAT_SUM, TIMEOUTS, LAST_LAT); end
  endtask

  task automatic test_single;
    model_sweep(RADDR, 0, 2, 1'b0);
    run_sweep(0, 2, 1'b0, 1'b0);
    total++; if (obs_expired) begin bad++; $display("FAIL single_timeout_budget got=expired want=done"); end
    total++; if (obs_busy_first !== 1'b1) begin bad++; $display("FAIL single_busy got=%b want=1", obs_busy_first); end
    total++; if (RADDR !== 4'd1) begin bad++; $display("FAIL single_raddr got=%0d want=1", RADDR); end
    total++; if (LAST_LAT !== 8'd2 || LAT_SUM !== 12'd2) begin bad++; $display("FAIL single_lat last=%0d sum=%0d want=2", LAST_LAT, LAT_SUM); end
    total++; if (MIN_LAT !== exp_min || MAX_LAT !== exp_max) begin
      bad++; $display("FAIL single_minmax min=%0d max=%0d want=%0d/%0d", MIN_LAT, MAX_LAT, exp_min, exp_max); end
    total++; if (obs_done != 1 || obs_done_after !== 1'b0) begin
      bad++; $display("FAIL single_done_pulse got=%0d,%b want=1,0", obs_done, obs_done_after); end
    total++; if (STATE !== 3'd0 || BUSY !== 1'b0) begin bad++; $display("FAIL single_idle state=%0d busy=%b want=0,0", STATE, BUSY); end
  endtask

  task automatic test_reset_mid_sweep;
    cfg_lat = 3; cfg_blank = 1'b0;
    repeat (10) @(negedge CLK);
    NUM = 4'd15; START = 1'b1;
    @(negedge CLK); START = 1'b0;
    repeat (12) @(negedge CLK);
    RST_N = 1'b0;
    @(negedge CLK); RST_N = 1'b1;
    total++; if (STATE !== 3'd0 || BUSY !== 1'b0 || DONE !== 1'b0) begin
      bad++; $display("FAIL midrst_ctrl state=%0d busy=%b done=%b want=0,0,0", STATE, BUSY, DONE); end
    total++; if (RADDR !== 4'd0 || LAST_LAT !== 8'd0 || MAX_LAT !== 8'd0) begin
      bad++; $display("FAIL midrst_regs raddr=%0d last=%0d max=%0d want=0", RADDR, LAST_LAT, MAX_LAT); end
    total++; if (LAT_SUM !== 12'd0 || TIMEOUTS !== 5'd0) begin
      bad++; $display("FAIL midrst_stats sum=%0d to=%0d want=0", LAT_SUM, TIMEOUTS); end
`ifdef RAM_LATENCY_MINMAX_EN
    total++; if (MIN_LAT !== 8'hFF) begin bad++; $display("FAIL midrst_min got=%0d want=255", MIN_LAT); end
`else
    total++; if (MIN_LAT !== 8'h00) begin bad++; $display("FAIL midrst_min got=%0d want=0", MIN_LAT); end
`endif
    run_sweep(0, 2, 1'b0, 1'b0);
    total++; if (RADDR !== 4'd1 || LAST_LAT !== 8'd2 || LAT_SUM !== 12'd2 || obs_done != 1) begin
      bad++; $display("FAIL midrst_fresh raddr=%0d last=%0d sum=%0d done=%0d want=1,2,2,1", RADDR, LAST_LAT, LAT_SUM, obs_done); end
  endtask

  task automatic test_full_sweep;
    RST_N = 1'b0;
    @(negedge CLK); RST_N = 1'b1;
    model_sweep(RADDR, 15, 3, 1'b0);
    run_sweep(15, 3, 1'b0, 1'b0);
    total++; if (LAT_SUM !== 12'd48 || TIMEOUTS !== 5'd0) begin
      bad++; $display("FAIL full_sum sum=%0d to=%0d want=48,0", LAT_SUM, TIMEOUTS); end
    total++; if (RADDR !== 4'd0 || obs_done != 1) begin bad++; $display("FAIL full_end raddr=%0d done=%0d want=0,1", RADDR, obs_done); end
    total++; if (obs_addrs.size() != 16) begin bad++; $display("FAIL full_addr_count got=%0d want=16", obs_addrs.size()); end
    else for (int i = 0; i < 16; i++) begin
      total++; if (obs_addrs[i] !== exp_addrs[i]) begin bad++; $display("FAIL full_addr[%0d] got=%0d want=%0d", i, obs_addrs[i], exp_addrs[i]); end
    end
  endtask

  task automatic test_timeout;
    run_sweep(1, 0, 1'b1, 1'b0);
    total++; if (LAST_LAT !== 8'd5 || TIMEOUTS !== 5'd2 || LAT_SUM !== 12'd0) begin
      bad++; $display("FAIL blank last=%0d to=%0d sum=%0d want=5,2,0", LAST_LAT, TIMEOUTS, LAT_SUM); end
    total++; if (obs_done != 1) begin bad++; $display("FAIL blank_done got=%0d want=1", obs_done); end
    // latency equal to TIMEOUT still counts as a hit; one more cycle is a timeout
    model_sweep(RADDR, 0, TMO, 1'b0);
    run_sweep(0, TMO, 1'b0, 1'b0);
    total++; if (LAST_LAT !== exp_last || LAT_SUM !== exp_sum || TIMEOUTS !== exp_to) begin
      bad++; $display("FAIL edge_hit last=%0d sum=%0d to=%0d want=%0d,%0d,%0d", LAST_LAT, LAT_SUM, TIMEOUTS, exp_last, exp_sum, exp_to); end
    model_sweep(RADDR, 0, TMO + 1, 1'b0);
    run_sweep(0, TMO + 1, 1'b0, 1'b0);
    total++; if (LAST_LAT !== exp_last || LAT_SUM !== exp_sum || TIMEOUTS !== exp_to) begin
      bad++; $display("FAIL edge_miss last=%0d sum=%0d to=%0d want=%0d,%0d,%0d", LAST_LAT, LAT_SUM, TIMEOUTS, exp_last, exp_sum, exp_to); end
  endtask

  task automatic test_abort;
    logic [3:0] prev;
    int changes = 0;
    int dones = 0;
    cfg_lat = 3; cfg_blank = 1'b0;
    repeat (10) @(negedge CLK);
    NUM = 4'd3; START = 1'b1; prev = RADDR;
    @(negedge CLK); START = 1'b0;
    for (int c = 0; c < 60 && changes < 2; c++) begin
      if (DONE) dones++;
      if (RADDR != prev) begin changes++; prev = RADDR; end
      if (changes < 2) @(negedge CLK);
    end
    total++; if (changes != 2) begin bad++; $display("FAIL abort_reach_sample2 got=%0d want=2", changes); end
    // ABORT lands on the very edge where sample 2 would match
    repeat (3) @(negedge CLK);
    ABORT = 1'b1;
    @(negedge CLK); ABORT = 1'b0;
    total++; if (STATE !== 3'd0 || BUSY !== 1'b0) begin bad++; $display("FAIL abort_idle state=%0d busy=%b want=0,0", STATE, BUSY); end
    total++; if (LAT_SUM !== 12'd3 || LAST_LAT !== 8'd3 || TIMEOUTS !== 5'd0) begin
      bad++; $display("FAIL abort_hold sum=%0d last=%0d to=%0d want=3,3,0", LAT_SUM, LAST_LAT, TIMEOUTS); end
    for (int c = 0; c < 10; c++) begin if (DONE) dones++; @(negedge CLK); end
    total++; if (dones != 0) begin bad++; $display("FAIL abort_no_done got=%0d want=0", dones); end
  endtask

  task automatic test_random;
    int n, lat;
    bit blank;
    for (int it = 0; it < 10; it++) begin
      n     = $urandom_range(0, 15);
      lat   = $urandom_range(0, 7);
      blank = ($urandom_range(0, 4) == 0);
      model_sweep(RADDR, n, lat, blank);
      run_sweep(n, lat, blank, 1'b1);
      total++; if (obs_expired || obs_done != 1 || obs_done_after !== 1'b0) begin
        bad++; $display("FAIL rnd%0d_done got=%0d,%b,%b want=1,0,0", it, obs_done, obs_done_after, obs_expired); end
      total++; if (RADDR !== exp_addr || LAST_LAT !== exp_last) begin
        bad++; $display("FAIL rnd%0d_addr_last got=%0d,%0d want=%0d,%0d", it, RADDR, LAST_LAT, exp_addr, exp_last); end
      total++; if (LAT_SUM !== exp_sum || TIMEOUTS !== exp_to) begin
        bad++; $display("FAIL rnd%0d_sum_to got=%0d,%0d want=%0d,%0d", it, LAT_SUM, TIMEOUTS, exp_sum, exp_to); end
      total++; if (MIN_LAT !== exp_min || MAX_LAT !== exp_max) begin
        bad++; $display("FAIL rnd%0d_minmax got=%0d,%0d want=%0d,%0d", it, MIN_LAT, MAX_LAT, exp_min, exp_max); end
      total++; if (obs_addrs.size() != exp_addrs.size()) begin
        bad++; $display("FAIL rnd%0d_addr_count got=%0d want=%0d", it, obs_addrs.size(), exp_addrs.size()); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_reset_mid_sweep();
    test_full_sweep();
    test_timeout();
    test_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_latency_probe.md
RAM_LATENCY_PROBE -- requirements
Module: ram_latency_probe

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, read-address width.
REQ-002 SHALL have parameter DATA_W, default 8, read-data width.
REQ-003 SHALL have parameter CNT_W, default 8, latency-counter width.
REQ-004 SHALL have parameter TIMEOUT, default 2**CNT_W-1, maximum wait cycles per sample.
REQ-005 SHALL have port CLK  in  1  sole clock, all logic on rising edge; same clock as RAM read port.
REQ-006 SHALL have port RST_N  in  1  reset, synchronous, active-low.
REQ-007 SHALL have port START  in  1  start sweep (level, sampled in IDLE only).
REQ-008 SHALL have port ABORT  in  1  abandon sweep.
REQ-009 SHALL have port NUM  in  ADDR_W  sample count minus one.
REQ-010 SHALL have port RADDR  out  ADDR_W  RAM read address.
REQ-011 SHALL have port RDATA  in  DATA_W  RAM read data.
REQ-012 SHALL have port BUSY  out  1  sweep in progress.
REQ-013 SHALL have port DONE  out  1  one-cycle completion pulse.
REQ-014 SHALL have ports LAST_LAT, MIN_LAT, MAX_LAT  out  CNT_W  latency statistics.
REQ-015 SHALL have port LAT_SUM  out  CNT_W+ADDR_W  summed latencies.
REQ-016 SHALL have port TIMEOUTS  out  ADDR_W+1  timed-out sample count.
REQ-017 SHALL have port STATE  out  3  current state code, for segment display.

Function
REQ-018 Expected data SHALL be RADDR zero-extended (or truncated) to DATA_W.
REQ-019 States SHALL be IDLE=0, WAIT=2, NEXT=3, DONE=4.
REQ-020 IDLE with START=1 SHALL: RADDR<=RADDR+1 (wraps), cnt<=0, clear all statistics (MIN_LAT to all-ones), sample index<=0, go WAIT.
REQ-021 WAIT SHALL compare RDATA to expected each cycle; match -> LAST_LAT<=cnt, update MIN/MAX/SUM, go NEXT.
REQ-022 WAIT no-match with cnt==TIMEOUT SHALL: LAST_LAT<=TIMEOUT, TIMEOUTS+1, no MIN/MAX/SUM update, go NEXT; else cnt+1.
REQ-023 Latency SHALL equal cycles from address-change edge to match edge (match on first WAIT cycle = 0).
REQ-024 NEXT SHALL go DONE when index==NUM, else RADDR+1 (wraps at 2**ADDR_W-1 to 0), index+1, cnt<=0, go WAIT.
REQ-025 DONE SHALL assert DONE for exactly one cycle, then go IDLE; statistics hold until next start.
REQ-026 BUSY SHALL be 1 in WAIT and NEXT, 0 otherwise.
REQ-027 START outside IDLE SHALL be ignored.
REQ-028 ABORT SHALL move any non-IDLE state to IDLE next cycle, no DONE, partial statistics held; ABORT beats match/timeout in same cycle.
REQ-029 LAT_SUM SHALL never overflow (width covers 2**ADDR_W samples of max CNT_W).

Reset
REQ-030 RST_N=0 at an edge SHALL force IDLE, RADDR=0, BUSY=0, DONE=0, LAST_LAT=MAX_LAT=LAT_SUM=TIMEOUTS=0, MIN_LAT=all-ones, including mid-sweep.

Configuration
REQ-031 Macro RAM_LATENCY_MINMAX_EN defined SHALL include MIN_LAT/MAX_LAT tracking; undefined SHALL tie both to 0 with no tracking registers.

Structure
REQ-032 Package ram_probe_pkg SHALL hold the state enum typedef and state-code constants.
REQ-033 Statistics (MIN/MAX/SUM/TIMEOUTS) SHALL be sub-module ram_lat_stats, fed by a sample-valid strobe, latency and timeout flag.

Verification
REQ-034 RAM model 2-cycle read latency, NUM=0, START -> RADDR=1, LAST_LAT=2, MIN=MAX=SUM=2, DONE one pulse.
REQ-035 Latency 3, NUM=15, RADDR start 0 -> addresses 1..15,0 read, SUM=48, TIMEOUTS=0.
REQ-036 RAM returning 0xFF forever, TIMEOUT=5, NUM=1 -> LAST_LAT=5, TIMEOUTS=2, SUM=0.
REQ-037 ABORT during WAIT of sample 2 -> IDLE next cycle, no DONE, BUSY=0, SUM holds first sample.
REQ-038 RST_N low mid-sweep then START -> all outputs at reset values, fresh sweep from RADDR=1.
